// File: rtl/top_pkg.sv
// -----------------------------------------------------------------------------
// top_pkg
// Shared definitions for the UART echo slice: bit-period computation, frame
// bit-count constants and the RX/TX state encodings.
// No ports; imported by top and uart_rx.
// -----------------------------------------------------------------------------
package top_pkg;

  // Data bits per 8N1 frame and the width of an index into them.
  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);

  // Clock cycles spent on each UART bit (integer division).
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver working on an already synchronized line.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-low reset
//   rx    - synchronized receive line, idle high
//   data  - last received byte, valid while valid=1
//   valid - one-cycle pulse when a byte with a good stop bit arrives
// -----------------------------------------------------------------------------
module uart_rx
  import top_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]     CNT_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]     CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT      = BIT_IDX_W'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0] bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
    end
  end

  // A low level (not just an edge) starts a frame, so a line that is already
  // low when reset releases is still treated as a start bit. After the
  // half-bit check every sample lands on a bit midpoint.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[7:1]};
          if (bit_q == LAST_BIT) state_d = RX_STOP;
          else                   bit_d   = bit_q + BIT_IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d = '0;
          if (rx) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            state_d = RX_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_WAIT_HIGH: begin
        // Framing error: a line stuck low must not look like a new start bit.
        cnt_d = '0;
        if (rx) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data  = shift_q;
  assign valid = valid_q;

endmodule

// File: rtl/top.sv
// -----------------------------------------------------------------------------
// top
// UART receiver with activity LED and optional echo transmitter.
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous, active-low reset
//   uart_rx  - asynchronous UART receive line, idle high
//   ledo     - toggles once per correctly framed received byte
//   uart_txo - UART transmit line, idle high
// Configuration macro:
//   UART_ECHO_EN - when defined, received bytes are retransmitted on uart_txo
//                  through a one-byte holding register; when undefined the
//                  transmitter is absent and uart_txo is tied high.
// -----------------------------------------------------------------------------
module top
  import top_pkg::*;
#(
  parameter int CLK_FREQ = 125_000_000,
  parameter int BAUD     = 115200
) (
  input  logic clk,
  input  logic reset,
  input  logic uart_rx,
  output logic ledo,
  output logic uart_txo
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);

  logic       sync1_q, sync2_q;
  logic       ledo_q, ledo_d;
  logic [7:0] rx_data;
  logic       rx_valid;

  // Two-flop synchronizer; flops reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
    end
  end

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk  (clk),
    .reset(reset),
    .rx   (sync2_q),
    .data (rx_data),
    .valid(rx_valid)
  );

  // The LED toggles for every good byte, including ones the echo path drops.
  assign ledo_d = ledo_q ^ rx_valid;

  always_ff @(posedge clk) begin
    if (!reset) ledo_q <= 1'b0;
    else        ledo_q <= ledo_d;
  end

  assign ledo = ledo_q;

`ifdef UART_ECHO_EN
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]     CNT_BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT     = BIT_IDX_W'(DATA_BITS - 1);

  tx_state_e            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_IDX_W-1:0] tx_bit_q, tx_bit_d;
  logic [7:0]           tx_shift_q, tx_shift_d;
  logic                 txo_q, txo_d;
  logic                 hold_full_q, hold_full_d;
  logic [7:0]           hold_data_q, hold_data_d;
  logic                 tx_accept;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      txo_q       <= 1'b1;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      txo_q       <= txo_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
    end
  end

  // The line level for the next bit is computed one cycle ahead so uart_txo
  // comes straight from a flop; each state lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txo_d      = txo_q;
    tx_accept  = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        txo_d = 1'b1;
        if (hold_full_q) begin
          tx_accept  = 1'b1;
          tx_shift_d = hold_data_q;
          tx_cnt_d   = '0;
          txo_d      = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txo_d      = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == LAST_BIT) begin
            txo_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + BIT_IDX_W'(1);
            txo_d      = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Holding register: a byte arriving while it is still occupied is lost,
  // unless the transmitter is emptying it in that same cycle.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    if (tx_accept) hold_full_d = 1'b0;
    if (rx_valid && (!hold_full_q || tx_accept)) begin
      hold_full_d = 1'b1;
      hold_data_d = rx_data;
    end
  end

  assign uart_txo = txo_q;
`else
  // Without echo the received byte has no consumer; fold it into a sink.
  logic unused_rx_data;
  assign unused_rx_data = ^rx_data;
  assign uart_txo       = 1'b1;
`endif

endmodule

// File: tb/tb_top.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_top
// Directed self-checking bench for top: reset state, 0xFA and 0x55 frames,
// start-bit glitch, framing error recovery and reset in the middle of an echo.
// Echo expectations follow the UART_ECHO_EN macro.
// -----------------------------------------------------------------------------
module tb_top;

  localparam int CPB  = 1085;
  localparam int HALF = CPB / 2;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic uart_rx = 1'b1;
  logic ledo;
  logic uart_txo;

  int   checks = 0;
  int   passed = 0;
  logic exp_led = 1'b0;

  top dut (
    .clk     (clk),
    .reset   (reset),
    .uart_rx (uart_rx),
    .ledo    (ledo),
    .uart_txo(uart_txo)
  );

  always #4 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      cycles(CPB);
    end
    uart_rx = stop_bit;
    cycles(CPB);
  endtask

  task automatic watch_txo_high(input int n, output logic all_high);
    all_high = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uart_txo !== 1'b1) all_high = 1'b0;
    end
  endtask

  task automatic wait_txo_fall(input int budget, output logic seen);
    int n = 0;
    while (uart_txo !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    seen = (uart_txo === 1'b0);
  endtask

  task automatic capture_tx(input int budget, output logic seen, output logic start_bit,
                            output logic [7:0] data, output logic stop_bit,
                            output logic idle_after);
    start_bit  = 1'b1;
    data       = 8'h00;
    stop_bit   = 1'b0;
    idle_after = 1'b0;
    wait_txo_fall(budget, seen);
    if (seen) begin
      cycles(HALF);
      start_bit = uart_txo;
      for (int i = 0; i < 8; i++) begin
        cycles(CPB);
        data[i] = uart_txo;
      end
      cycles(CPB);
      stop_bit = uart_txo;
      cycles(CPB - HALF + 2);
      idle_after = uart_txo;
    end
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    uart_rx = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({uart_txo, ledo} !== 2'b10)
        $display("[TB] FAIL reset_hold cycle %0d: txo/ledo got %b%b want 10", i, uart_txo, ledo);
      else passed++;
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({uart_txo, ledo} !== 2'b10)
        $display("[TB] FAIL reset_release cycle %0d: txo/ledo got %b%b want 10", i, uart_txo, ledo);
      else passed++;
    end
  endtask

  task automatic test_fa_frame();
    logic seen, sb, pb, idle, hi;
    logic [7:0] d;
    seen = 1'b0; sb = 1'b1; pb = 1'b0; idle = 1'b0; hi = 1'b1; d = 8'h00;
    reset   = 1'b0;
    uart_rx = 1'b0;
    cycles(5);
    reset   = 1'b1;
    exp_led = 1'b0;
    cycles(100);
    fork
      begin
        uart_rx = 1'b0; cycles(CPB);
        uart_rx = 1'b0; cycles(CPB);
        uart_rx = 1'b1; cycles(CPB);
        uart_rx = 1'b0; cycles(CPB);
        uart_rx = 1'b1;
      end
`ifdef UART_ECHO_EN
      capture_tx(12000, seen, sb, d, pb, idle);
`else
      watch_txo_high(12000, hi);
`endif
    join
    exp_led = ~exp_led;
`ifdef UART_ECHO_EN
    checks++;
    if (seen !== 1'b1) $display("[TB] FAIL fa_echo_seen: got %b want 1", seen); else passed++;
    checks++;
    if (sb !== 1'b0) $display("[TB] FAIL fa_echo_start: got %b want 0", sb); else passed++;
    checks++;
    if (d !== 8'hFA) $display("[TB] FAIL fa_echo_data: got %h want fa", d); else passed++;
    checks++;
    if (pb !== 1'b1) $display("[TB] FAIL fa_echo_stop: got %b want 1", pb); else passed++;
    checks++;
    if (idle !== 1'b1) $display("[TB] FAIL fa_echo_idle: got %b want 1", idle); else passed++;
`else
    checks++;
    if (hi !== 1'b1) $display("[TB] FAIL fa_txo_high: got %b want 1", hi); else passed++;
`endif
    checks++;
    if (ledo !== exp_led) $display("[TB] FAIL fa_ledo: got %b want %b", ledo, exp_led); else passed++;
  endtask

  task automatic test_frame_55();
    logic seen, sb, pb, idle, hi;
    logic [7:0] d;
    seen = 1'b0; sb = 1'b1; pb = 1'b0; idle = 1'b0; hi = 1'b1; d = 8'h00;
    uart_rx = 1'b1;
    cycles(20);
    fork
      send_frame(8'h55, 1'b1);
`ifdef UART_ECHO_EN
      capture_tx(12000, seen, sb, d, pb, idle);
`else
      watch_txo_high(12000, hi);
`endif
    join
    exp_led = ~exp_led;
`ifdef UART_ECHO_EN
    checks++;
    if (seen !== 1'b1) $display("[TB] FAIL x55_echo_seen: got %b want 1", seen); else passed++;
    checks++;
    if (sb !== 1'b0) $display("[TB] FAIL x55_echo_start: got %b want 0", sb); else passed++;
    checks++;
    if (d !== 8'h55) $display("[TB] FAIL x55_echo_data: got %h want 55", d); else passed++;
    checks++;
    if (pb !== 1'b1) $display("[TB] FAIL x55_echo_stop: got %b want 1", pb); else passed++;
    checks++;
    if (idle !== 1'b1) $display("[TB] FAIL x55_echo_idle: got %b want 1", idle); else passed++;
`else
    checks++;
    if (hi !== 1'b1) $display("[TB] FAIL x55_txo_high: got %b want 1", hi); else passed++;
`endif
    checks++;
    if (ledo !== exp_led) $display("[TB] FAIL x55_ledo: got %b want %b", ledo, exp_led); else passed++;
  endtask

  task automatic test_glitch();
    logic hi;
    uart_rx = 1'b0;
    cycles(300);
    uart_rx = 1'b1;
    watch_txo_high(2000, hi);
    checks++;
    if (hi !== 1'b1) $display("[TB] FAIL glitch_txo_high: got %b want 1", hi); else passed++;
    checks++;
    if (ledo !== exp_led) $display("[TB] FAIL glitch_ledo: got %b want %b", ledo, exp_led); else passed++;
  endtask

  task automatic test_framing_error();
    logic hi, hi2, seen;
    hi = 1'b1; hi2 = 1'b1; seen = 1'b0;
    fork
      begin
        send_frame(8'hA5, 1'b0);
        cycles(3000);
        uart_rx = 1'b1;
      end
      watch_txo_high(10 * CPB + 3000 + 50, hi);
    join
    checks++;
    if (hi !== 1'b1) $display("[TB] FAIL frame_err_no_echo: got %b want 1", hi); else passed++;
    checks++;
    if (ledo !== exp_led) $display("[TB] FAIL frame_err_ledo: got %b want %b", ledo, exp_led); else passed++;
    cycles(100);
    fork
      send_frame(8'h3C, 1'b1);
`ifdef UART_ECHO_EN
      wait_txo_fall(12000, seen);
`else
      watch_txo_high(10 * CPB + 100, hi2);
`endif
    join
    exp_led = ~exp_led;
    checks++;
    if (ledo !== exp_led) $display("[TB] FAIL recover_ledo: got %b want %b", ledo, exp_led); else passed++;
`ifdef UART_ECHO_EN
    checks++;
    if (seen !== 1'b1) $display("[TB] FAIL recover_echo_start: got %b want 1", seen); else passed++;
`else
    checks++;
    if (hi2 !== 1'b1) $display("[TB] FAIL recover_txo_high: got %b want 1", hi2); else passed++;
`endif
  endtask

  // Entered roughly 540 cycles into the echo of 0x3C; 2000 more lands in
  // data bit 1, which is 0.
  task automatic test_reset_mid_echo();
    logic hi;
    logic exp_pre;
`ifdef UART_ECHO_EN
    exp_pre = 1'b0;
`else
    exp_pre = 1'b1;
`endif
    cycles(2000);
    checks++;
    if (uart_txo !== exp_pre)
      $display("[TB] FAIL mid_echo_pre_reset: got %b want %b", uart_txo, exp_pre);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (uart_txo !== 1'b1) $display("[TB] FAIL mid_echo_reset_txo: got %b want 1", uart_txo); else passed++;
    checks++;
    if (ledo !== 1'b0) $display("[TB] FAIL mid_echo_reset_ledo: got %b want 0", ledo); else passed++;
    cycles(2);
    reset   = 1'b1;
    exp_led = 1'b0;
    watch_txo_high(100, hi);
    checks++;
    if (hi !== 1'b1) $display("[TB] FAIL post_reset_txo_high: got %b want 1", hi); else passed++;
  endtask

  initial begin
    test_reset();
    test_fa_frame();
    test_frame_55();
    test_glitch();
    test_framing_error();
    test_reset_mid_echo();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
